// File: rtl/mem_arbiter_if.sv
// Downstream SRAM-like memory bus shared by the fetch and data sides.
// The arbiter is the master; the memory (or its controller) is the slave.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic              mem_req;
  logic              mem_wr;
  logic [DW/8-1:0]   mem_wstrb;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic              mem_addr_ok;
  logic              mem_data_ok;
  logic [DW-1:0]     mem_rdata;

  modport master (
    output mem_req,
    output mem_wr,
    output mem_wstrb,
    output mem_addr,
    output mem_wdata,
    input  mem_addr_ok,
    input  mem_data_ok,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_wr,
    input  mem_wstrb,
    input  mem_addr,
    input  mem_wdata,
    output mem_addr_ok,
    output mem_data_ok,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arbiter.sv
// Serialises instruction-fetch and data accesses onto one memory port, data first,
// and buffers each result until the pipeline advances so no stall loses data.
module mem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            inst_en,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            i_stall,

  input  logic            data_en,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            d_stall,

  input  logic            longest_stall,

  mem_arbiter_if.master   mem
);

  localparam int SW = DW / 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_D_ADDR = 3'd1,
    S_D_DATA = 3'd2,
    S_I_ADDR = 3'd3,
    S_I_DATA = 3'd4
  } state_t;

  state_t          state_q,      state_d;
  logic            mem_req_q,    mem_req_d;
  logic            mem_wr_q,     mem_wr_d;
  logic [SW-1:0]   mem_wstrb_q,  mem_wstrb_d;
  logic [AW-1:0]   mem_addr_q,   mem_addr_d;
  logic [DW-1:0]   mem_wdata_q,  mem_wdata_d;
  logic            i_done_q,     i_done_d;
  logic            d_done_q,     d_done_d;
  logic [DW-1:0]   inst_rdata_q, inst_rdata_d;
  logic [DW-1:0]   data_rdata_q, data_rdata_d;

  logic            d_pend;
  logic            i_pend;
  logic            d_set;
  logic            i_set;

  assign d_pend = data_en & ~d_done_q;
  assign i_pend = inst_en & ~i_done_q;

  // Next-state and next-output computation for the arbitration FSM.
  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_wr_d     = mem_wr_q;
    mem_wstrb_d  = mem_wstrb_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    d_set        = 1'b0;
    i_set        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (d_pend) begin
          state_d     = S_D_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = |data_wen;
          mem_wstrb_d = data_wen;
          mem_addr_d  = data_addr;
          mem_wdata_d = data_wdata;
        end else if (i_pend) begin
          state_d     = S_I_ADDR;
          mem_req_d   = 1'b1;
          mem_wr_d    = 1'b0;
          mem_wstrb_d = {SW{1'b0}};
          mem_addr_d  = inst_addr;
        end else begin
          state_d     = S_IDLE;
        end
      end

      S_D_ADDR: begin
        if (mem.mem_addr_ok) begin
          state_d   = S_D_DATA;
          mem_req_d = 1'b0;
        end else begin
          state_d   = S_D_ADDR;
        end
      end

      S_D_DATA: begin
        if (mem.mem_data_ok) begin
          state_d = S_IDLE;
          d_set   = 1'b1;
          // A store acknowledge carries no data; keep the last load result.
          if (!mem_wr_q) begin
            data_rdata_d = mem.mem_rdata;
          end else begin
            data_rdata_d = data_rdata_q;
          end
        end else begin
          state_d = S_D_DATA;
        end
      end

      S_I_ADDR: begin
        if (mem.mem_addr_ok) begin
          state_d   = S_I_DATA;
          mem_req_d = 1'b0;
        end else begin
          state_d   = S_I_ADDR;
        end
      end

      S_I_DATA: begin
        if (mem.mem_data_ok) begin
          state_d      = S_IDLE;
          i_set        = 1'b1;
          inst_rdata_d = mem.mem_rdata;
        end else begin
          state_d      = S_I_DATA;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
      end
    endcase

    // A completion in this cycle wins over the pipeline-advance clear.
    d_done_d = d_set | (d_done_q & longest_stall);
    i_done_d = i_set | (i_done_q & longest_stall);
  end

  // State and registered outputs, cleared by the shared synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_wstrb_q  <= {SW{1'b0}};
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      inst_rdata_q <= {DW{1'b0}};
      data_rdata_q <= {DW{1'b0}};
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_wr_q     <= mem_wr_d;
      mem_wstrb_q  <= mem_wstrb_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i_done_q     <= i_done_d;
      d_done_q     <= d_done_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_wr    = mem_wr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;

  assign inst_rdata = inst_rdata_q;
  assign data_rdata = data_rdata_q;
  assign i_stall    = inst_en & ~i_done_q;
  assign d_stall    = data_en & ~d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed timeline cases plus a randomized run, all checked
// every cycle against a transaction-level model of the shared memory port.
module tb_mem_arbiter;

  localparam int          AW   = 32;
  localparam int          DW   = 32;
  localparam int          SW   = DW / 8;
  localparam logic [31:0] SALT = 32'h5A5A0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_en;
  logic [AW-1:0]   inst_addr;
  logic [DW-1:0]   inst_rdata;
  logic            i_stall;
  logic            data_en;
  logic [SW-1:0]   data_wen;
  logic [AW-1:0]   data_addr;
  logic [DW-1:0]   data_wdata;
  logic [DW-1:0]   data_rdata;
  logic            d_stall;
  logic            longest_stall;

  mem_arbiter_if #(.AW(AW), .DW(DW)) mem_bus ();

  mem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_en       (inst_en),
    .inst_addr     (inst_addr),
    .inst_rdata    (inst_rdata),
    .i_stall       (i_stall),
    .data_en       (data_en),
    .data_wen      (data_wen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_rdata    (data_rdata),
    .d_stall       (d_stall),
    .longest_stall (longest_stall),
    .mem           (mem_bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents seen by the slave: one fixed boot instruction, otherwise address ^ SALT.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC00000) return 32'h3C080001;
    else return a ^ SALT;
  endfunction

  // ---------------- slave model ----------------
  bit          rand_mode = 1'b0;
  bit          noise_en  = 1'b0;
  logic        force_dok = 1'b0;
  int          aw_cfg = 0;
  int          dw_cfg = 0;
  int          a_cnt = 0;
  int          d_cnt = 0;
  int          aw_r = 0;
  int          dw_r = 0;
  logic        pend = 1'b0;
  logic [31:0] rd_addr = 32'h0;
  logic        noise_q = 1'b0;
  logic [31:0] junk_q = 32'h0;
  int          aw_eff;
  int          dw_eff;

  assign aw_eff = rand_mode ? aw_r : aw_cfg;
  assign dw_eff = rand_mode ? dw_r : dw_cfg;
  assign mem_bus.mem_addr_ok = mem_bus.mem_req ? (a_cnt == aw_eff) : noise_q;
  assign mem_bus.mem_data_ok = pend ? (d_cnt == dw_eff) : (noise_q | force_dok);
  assign mem_bus.mem_rdata   = pend ? mem_word(rd_addr) : junk_q;

  always @(posedge clk) begin
    noise_q <= noise_en && ($urandom_range(0, 3) == 0);
    junk_q  <= $urandom;
    if (rst) begin
      a_cnt <= 0; d_cnt <= 0; pend <= 1'b0; aw_r <= 0; dw_r <= 0;
    end else begin
      if (mem_bus.mem_req && mem_bus.mem_addr_ok) begin
        pend    <= 1'b1;
        d_cnt   <= 0;
        a_cnt   <= 0;
        rd_addr <= mem_bus.mem_addr;
        dw_r    <= $urandom_range(0, 3);
      end else if (mem_bus.mem_req) begin
        a_cnt <= a_cnt + 1;
      end
      if (pend) begin
        if (mem_bus.mem_data_ok) begin
          pend <= 1'b0;
          aw_r <= $urandom_range(0, 3);
        end else begin
          d_cnt <= d_cnt + 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // One outstanding-transaction record: 0 = none, 1 = requesting, 2 = awaiting response.
  int          m_phase = 0;
  bit          m_is_d = 1'b0;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic [3:0]  m_strb = 4'h0;
  logic        m_wr = 1'b0;
  logic        m_idone = 1'b0;
  logic        m_ddone = 1'b0;
  logic [31:0] m_ird = 32'h0;
  logic [31:0] m_drd = 32'h0;

  always @(posedge clk) begin : model
    logic set_i;
    logic set_d;
    set_i = 1'b0;
    set_d = 1'b0;
    if (rst) begin
      m_phase = 0; m_is_d = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_strb = 4'h0;
      m_wr = 1'b0; m_idone = 1'b0; m_ddone = 1'b0; m_ird = 32'h0; m_drd = 32'h0;
    end else begin
      if (m_phase == 0) begin
        if (data_en && !m_ddone) begin
          m_phase = 1; m_is_d = 1'b1; m_addr = data_addr; m_wdata = data_wdata;
          m_strb = data_wen; m_wr = (data_wen != 4'h0);
        end else if (inst_en && !m_idone) begin
          m_phase = 1; m_is_d = 1'b0; m_addr = inst_addr; m_strb = 4'h0; m_wr = 1'b0;
        end
      end else if (m_phase == 1) begin
        if (mem_bus.mem_addr_ok) m_phase = 2;
      end else begin
        if (mem_bus.mem_data_ok) begin
          m_phase = 0;
          if (m_is_d) begin
            set_d = 1'b1;
            if (!m_wr) m_drd = mem_bus.mem_rdata;
          end else begin
            set_i = 1'b1;
            m_ird = mem_bus.mem_rdata;
          end
        end
      end
      m_ddone = set_d | (m_ddone & longest_stall);
      m_idone = set_i | (m_idone & longest_stall);
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("mem_req",    32'(mem_bus.mem_req), 32'(m_phase == 1));
      chk("i_stall",    32'(i_stall),         32'(inst_en & ~m_idone));
      chk("d_stall",    32'(d_stall),         32'(data_en & ~m_ddone));
      chk("inst_rdata", inst_rdata,           m_ird);
      chk("data_rdata", data_rdata,           m_drd);
      if (m_phase == 1) begin
        chk("mem_addr",  mem_bus.mem_addr,       m_addr);
        chk("mem_wr",    32'(mem_bus.mem_wr),    32'(m_wr));
        chk("mem_wstrb", 32'(mem_bus.mem_wstrb), 32'(m_strb));
        if (m_is_d && m_wr) chk("mem_wdata", mem_bus.mem_wdata, m_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; inst_en = 1'b0; inst_addr = 32'h0; data_en = 1'b0; data_wen = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0; longest_stall = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_mem_req",    32'(mem_bus.mem_req),   32'h0);
    chk("rst_mem_addr",   mem_bus.mem_addr,       32'h0);
    chk("rst_mem_wdata",  mem_bus.mem_wdata,      32'h0);
    chk("rst_mem_wstrb",  32'(mem_bus.mem_wstrb), 32'h0);
    chk("rst_inst_rdata", inst_rdata,             32'h0);
    chk("rst_data_rdata", data_rdata,             32'h0);

    // Fetch only, zero wait.
    @(negedge clk); #2;
    inst_en = 1'b1; inst_addr = 32'hBFC00000; #1;
    chk("t1_istall_c0", 32'(i_stall), 32'h1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t1_req",    32'(mem_bus.mem_req), 32'(k == 1));
      chk("t1_istall", 32'(i_stall),         32'(k < 3));
      if (k == 3) begin
        chk("t1_rdata", inst_rdata, 32'h3C080001);
        #2 inst_en = 1'b0;
      end
    end

    // Fetch and load in the same cycle: data goes first.
    @(negedge clk); #2;
    inst_en = 1'b1; inst_addr = 32'hBFC00000;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80000010; #1;
    chk("t2_dstall_c0", 32'(d_stall), 32'h1);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("t2_req",    32'(mem_bus.mem_req), 32'(k == 1 || k == 4));
      chk("t2_dstall", 32'(d_stall),         32'(k < 3));
      chk("t2_istall", 32'(i_stall),         32'(k < 6));
      if (k == 1) begin
        chk("t2_addr_d", mem_bus.mem_addr,    32'h80000010);
        chk("t2_wr_d",   32'(mem_bus.mem_wr), 32'h0);
      end
      if (k == 4) chk("t2_addr_i", mem_bus.mem_addr, 32'hBFC00000);
      if (k == 3) begin
        chk("t2_drdata", data_rdata, 32'hDA5A0010);
        #2 data_en = 1'b0;
      end
      if (k == 6) begin
        chk("t2_irdata", inst_rdata, 32'h3C080001);
        #2 inst_en = 1'b0;
      end
    end

    // Store with addr_ok delayed two cycles.
    @(negedge clk); #2;
    aw_cfg = 2;
    data_en = 1'b1; data_wen = 4'b0011; data_wdata = 32'h1234ABCD; data_addr = 32'h80000020; #1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("t3_req",    32'(mem_bus.mem_req), 32'(k <= 3));
      chk("t3_dstall", 32'(d_stall),         32'(k < 5));
      if (k <= 3) begin
        chk("t3_addr",  mem_bus.mem_addr,       32'h80000020);
        chk("t3_wdata", mem_bus.mem_wdata,      32'h1234ABCD);
        chk("t3_wr",    32'(mem_bus.mem_wr),    32'h1);
        chk("t3_wstrb", 32'(mem_bus.mem_wstrb), 32'h3);
      end
      if (k == 5) begin
        chk("t3_drdata_hold", data_rdata, 32'hDA5A0010);
        #2 data_en = 1'b0; aw_cfg = 0;
      end
    end

    // Load completing under a global freeze.
    @(negedge clk); #2;
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80000040; longest_stall = 1'b1; #1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) chk("t4_req1", 32'(mem_bus.mem_req), 32'h1);
      if (k >= 3 && k <= 7) begin
        chk("t4_noreq",  32'(mem_bus.mem_req), 32'h0);
        chk("t4_dstall", 32'(d_stall),         32'h0);
        chk("t4_drdata", data_rdata,           32'hDA5A0040);
      end
      if (k == 7) #2 longest_stall = 1'b0;
      if (k == 8) begin
        chk("t4_cleared", 32'(d_stall), 32'h1);
        #2 data_en = 1'b0;
      end
      if (k == 9) chk("t4_noreissue", 32'(mem_bus.mem_req), 32'h0);
    end

    // Reset while a fetch is waiting for its response.
    @(negedge clk); #2;
    dw_cfg = 10; inst_en = 1'b1; inst_addr = 32'hBFC00100; #1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 1) chk("t5_req1", 32'(mem_bus.mem_req), 32'h1);
      if (k == 2) begin
        chk("t5_idata", 32'(mem_bus.mem_req), 32'h0);
        #2 rst = 1'b1; force_dok = 1'b1;
      end
      if (k == 3) begin
        chk("t5_rst_req",    32'(mem_bus.mem_req), 32'h0);
        chk("t5_rst_addr",   mem_bus.mem_addr,     32'h0);
        chk("t5_rst_irdata", inst_rdata,           32'h0);
        chk("t5_rst_drdata", data_rdata,           32'h0);
        chk("t5_rst_istall", 32'(i_stall),         32'h1);
        #2 rst = 1'b0; dw_cfg = 0;
      end
      if (k == 4) begin
        chk("t5_reissue",      32'(mem_bus.mem_req), 32'h1);
        chk("t5_reissue_addr", mem_bus.mem_addr,     32'hBFC00100);
        chk("t5_late_ignored", inst_rdata,           32'h0);
        #2 force_dok = 1'b0;
      end
      if (k == 6) begin
        chk("t5_istall", 32'(i_stall), 32'h0);
        chk("t5_irdata", inst_rdata,   32'hE59A0100);
        #2 inst_en = 1'b0;
      end
    end

    // Data request arriving mid-fetch waits for the fetch.
    @(negedge clk); #2;
    dw_cfg = 3; inst_en = 1'b1; inst_addr = 32'hBFC00200; #1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 1) chk("t6_req_i", 32'(mem_bus.mem_req), 32'h1);
      if (k >= 2 && k <= 6) chk("t6_noovl", 32'(mem_bus.mem_req), 32'h0);
      if (k >= 3 && k <= 5) chk("t6_dwait", 32'(d_stall), 32'h1);
      if (k == 2) begin
        #2 data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80000080;
      end
      if (k == 6) begin
        chk("t6_istall", 32'(i_stall), 32'h0);
        chk("t6_irdata", inst_rdata,   32'hE59A0200);
        #2 inst_en = 1'b0; dw_cfg = 0;
      end
      if (k == 7) begin
        chk("t6_req_d",  32'(mem_bus.mem_req), 32'h1);
        chk("t6_addr_d", mem_bus.mem_addr,     32'h80000080);
      end
      if (k == 9) begin
        chk("t6_dstall", 32'(d_stall), 32'h0);
        chk("t6_drdata", data_rdata,   32'hDA5A0080);
        #2 data_en = 1'b0;
      end
    end

    // Randomized traffic, slave latencies, spurious handshakes, freezes and resets.
    rand_mode = 1'b1;
    noise_en  = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #2;
      rst = ($urandom_range(0, 299) == 0);
      longest_stall = ($urandom_range(0, 3) == 0);
      if (!(inst_en && !m_idone)) begin
        inst_en   = ($urandom_range(0, 9) < 7);
        inst_addr = $urandom & 32'hFFFFFFFC;
      end
      if (!(data_en && !m_ddone)) begin
        data_en    = ($urandom_range(0, 9) < 6);
        data_addr  = $urandom & 32'hFFFFFFFC;
        data_wdata = $urandom;
        data_wen   = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      end
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one SRAM-like memory port between the instruction-fetch port and the data-access port of the 5-stage MIPS pipeline. It serialises the two requesters, gives the data side priority, and returns per-side stall signals to the hazard unit (`i_stall`, `d_stall`). Each completed result is held in a buffer until the pipeline advances, so a stall caused by one side never loses the other side's data.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (`DW/8` byte strobes)

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `inst_en`  in  1  fetch request (level; held stable while `i_stall`=1)
- `inst_addr`  in  AW  fetch address
- `inst_rdata`  out  DW  fetched word (buffered)
- `i_stall`  out  1  fetch not yet complete
- `data_en`  in  1  load/store request (level; held stable while `d_stall`=1)
- `data_wen`  in  DW/8  byte write enables; 0 = load
- `data_addr`  in  AW  data address
- `data_wdata`  in  DW  store data
- `data_rdata`  out  DW  load result (buffered)
- `d_stall`  out  1  data access not yet complete
- `longest_stall`  in  1  global pipeline freeze from the hazard unit
- `mem_req`  out  1  downstream request
- `mem_wr`  out  1  1 = write
- `mem_wstrb`  out  DW/8  byte strobes
- `mem_addr`  out  AW  downstream address
- `mem_wdata`  out  DW  downstream write data
- `mem_addr_ok`  in  1  request accepted (handshake when `mem_req & mem_addr_ok`)
- `mem_data_ok`  in  1  response valid (read data or write ack)
- `mem_rdata`  in  DW  downstream read data

## Operation
- FSM states: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA.
- Pending conditions:
  - `d_pend` = `data_en & ~d_done`
  - `i_pend` = `inst_en & ~i_done`
- IDLE:
  - If `d_pend`: go to D_ADDR. Latch `mem_addr`, `mem_wdata` and `mem_wstrb` from the data port; set `mem_wr` = |`data_wen`.
  - Otherwise, if `i_pend`: go to I_ADDR. Latch `inst_addr`, with `mem_wr`=0 and `mem_wstrb`=0.
  - Data always beats fetch on the same cycle.
- x_ADDR: `mem_req`=1. On `mem_addr_ok`, go to x_DATA and drop `mem_req`.
- x_DATA: on `mem_data_ok`:
  - Capture `mem_rdata` into `data_rdata` or `inst_rdata`. On a write, `data_rdata` is left unchanged.
  - Set `d_done` or `i_done`.
  - Go to IDLE.
- No preemption: a data request arriving during an I transaction waits for that transaction to finish.
- Stall outputs are registered-flag based:
  - `d_stall` = `data_en & ~d_done`
  - `i_stall` = `inst_en & ~i_done`
- Done flags clear on any clock edge where `longest_stall`=0 (the pipeline advances). While `longest_stall`=1, a set flag and its buffered rdata hold, so nothing is re-issued.
- Setting a flag takes priority over clearing it. The clear applies only to flags already set at the start of the cycle.
- Reset: FSM goes to IDLE.
  - `mem_req`, `mem_wr`, `mem_wstrb`, `mem_addr`, `mem_wdata`, `i_done`, `d_done`, `inst_rdata` and `data_rdata` all clear to 0.
  - An in-flight transaction is abandoned; the downstream slave shares `rst`.
- `mem_data_ok` outside the x_DATA states is ignored.

## Timing
- Best case per access:
  - Cycle 0: request visible in IDLE.
  - Cycle 1: `mem_req`=1, `addr_ok`=1.
  - Cycle 2: `data_ok`=1.
  - Cycle 3: done=1, so stall=0.
- Best-case stall is therefore 3 cycles.
- Simultaneous fetch and load, zero wait: `d_stall` falls at cycle 3. I_ADDR starts at cycle 4, so `i_stall` falls at cycle 6.
- `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_wr` are stable from the cycle `mem_req` rises until the `addr_ok` handshake.
- `mem_req` falls the cycle after the handshake and never rises again before the matching `data_ok`. At most one transaction is outstanding.
- Throughput ceiling: one access per 3 cycles.

## Test plan
- Fetch only, zero-wait slave, `inst_addr`=0xBFC00000 returning 0x3C080001 -> `mem_req` high exactly in cycle 1. `i_stall`=1 for cycles 0-2 and 0 from cycle 3. `inst_rdata`=0x3C080001.
- Fetch and load same cycle, load `data_addr`=0x80000010 -> first `mem_addr`=0x80000010 with `mem_wr`=0, then 0xBFC00000. `d_stall` falls at cycle 3, `i_stall` at cycle 6.
- Store `data_wen`=4'b0011, `data_wdata`=0x1234ABCD, `addr_ok` delayed 2 cycles -> `mem_wr`=1 and `mem_wstrb`=0011. Address and data stay stable for all 3 `mem_req` cycles. `data_rdata` is unchanged.
- Load completes while `longest_stall`=1 for 5 cycles -> no second `mem_req`. `d_stall` stays 0 and `data_rdata` holds. `d_done` clears on the first edge with `longest_stall`=0.
- `rst` asserted in I_DATA -> next cycle the FSM is in IDLE with all outputs 0. A late `mem_data_ok` is ignored. The fetch is re-issued after reset is released.
- Fetch in I_DATA while `data_en` rises -> the fetch completes first, then D_ADDR begins with no overlapping `mem_req`.
